// File: rtl/btn_cond_if.sv
// btn_cond_if: raw switch in, conditioned level
// and pulse outputs back to the consumer.
interface btn_cond_if;
    logic i_btn;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_repeat;
    logic o_long;

    modport master (
        output i_btn,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_repeat,
        input  o_long
    );

    modport slave (
        input  i_btn,
        output o_level,
        output o_press,
        output o_release,
        output o_repeat,
        output o_long
    );
endinterface

// File: rtl/btn_cond.sv
// btn_cond: push-button synchroniser, debouncer and
// press/release/auto-repeat pulse generator.
module btn_cond #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int DEB_MS  = 20,
    parameter int HOLD_MS = 800,
    parameter int RPT_MS  = 200,
    parameter bit ACT_LOW = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    btn_cond_if.slave bus
);
    localparam int DEB_CYC  = CLK_HZ / 1000 * DEB_MS;
    localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
    localparam int RPT_CYC  = CLK_HZ / 1000 * RPT_MS;

    localparam logic [31:0] DEB_END  = 32'(DEB_CYC - 1);
    localparam logic [31:0] HOLD_END = 32'(HOLD_CYC - 1);
    localparam logic [31:0] RPT_END  = 32'(RPT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCHK,
        S_PRESSED,
        S_RPT,
        S_RCHK
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        sync1_q, sync2_q;
    logic        p;

    logic level_q, level_d;
    logic press_q, press_d;
    logic rel_q,   rel_d;
    logic rpt_q,   rpt_d;
    logic long_q,  long_d;

    // two-flop synchroniser, parked at the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACT_LOW;
            sync2_q <= ACT_LOW;
        end else begin
            sync1_q <= bus.i_btn;
            sync2_q <= sync1_q;
        end
    end

    assign p = sync2_q ^ ACT_LOW;

    // state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rpt_q   <= rpt_d;
            long_q  <= long_d;
        end
    end

    // next state; a change of p always wins over terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (p) state_d = S_PCHK;
            end
            S_PCHK: begin
                if (!p) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_END) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end
            end
            S_PRESSED: begin
                if (!p) begin
                    state_d = S_RCHK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_END) begin
                    state_d = S_RPT;
                    cnt_d   = '0;
                end
            end
            S_RPT: begin
                if (!p) begin
                    state_d = S_RCHK;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_END) begin
                    cnt_d = '0;
                end
            end
            S_RCHK: begin
                if (p) begin
                    state_d = long_q ? S_RPT : S_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // pulse and level updates for the next edge
    always_comb begin
        level_d = level_q;
        long_d  = long_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rpt_d   = 1'b0;
        unique case (state_q)
            S_PCHK: begin
                if (p && cnt_q == DEB_END) begin
                    level_d = 1'b1;
                    press_d = 1'b1;
                end
            end
            S_PRESSED: begin
                if (p && cnt_q == HOLD_END) begin
                    rpt_d  = 1'b1;
                    long_d = 1'b1;
                end
            end
            S_RPT: begin
                if (p && cnt_q == RPT_END) rpt_d = 1'b1;
            end
            S_RCHK: begin
                if (!p && cnt_q == DEB_END) begin
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                    long_d  = 1'b0;
                end
            end
            default: begin
                level_d = level_q;
            end
        endcase
    end

    assign bus.o_level   = level_q;
    assign bus.o_press   = press_q;
    assign bus.o_release = rel_q;
    assign bus.o_repeat  = rpt_q;
    assign bus.o_long    = long_q;
endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: directed scenarios plus random bouncing
// checked every cycle against a run-length model.
module tb_btn_cond;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic clk = 1'b0;
    logic rst_n;

    btn_cond_if bus ();

    btn_cond #(
        .CLK_HZ (1000),
        .DEB_MS (4),
        .HOLD_MS(10),
        .RPT_MS (3),
        .ACT_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    bit s1, s2, prev_p;
    int one_run, zero_run, tref;
    bit m_lvl, m_press, m_rel, m_rpt, m_long;

    int n_press, n_rel, n_rpt;
    int last_press, last_rel, first_rpt;
    int first_long, last_long;

    task automatic model_reset();
        s1 = 0; s2 = 0; prev_p = 0;
        one_run = 0; zero_run = 0; tref = 0;
        m_lvl = 0; m_press = 0; m_rel = 0;
        m_rpt = 0; m_long = 0;
    endtask

    // p seen by the conditioner at edge n is the raw
    // pressed level sampled at edge n-2
    task automatic model_step(input bit raw);
        bit p;
        p = s2;
        s2 = s1;
        s1 = raw;
        m_press = 0; m_rel = 0; m_rpt = 0;
        if (p) begin
            one_run++;
            zero_run = 0;
        end else begin
            zero_run++;
            one_run = 0;
        end
        if (!m_lvl) begin
            if (p && one_run == DEB + 1) begin
                m_lvl = 1; m_press = 1; tref = cyc;
            end
        end else if (!p) begin
            if (zero_run == DEB + 1) begin
                m_rel = 1; m_lvl = 0; m_long = 0;
            end
        end else if (!prev_p) begin
            tref = cyc;
        end else if (cyc - tref == (m_long ? RPT : HOLD)) begin
            m_rpt = 1; m_long = 1; tref = cyc;
        end
        prev_p = p;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                model_step(!bus.i_btn);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                total++;
                if ({bus.o_level, bus.o_press, bus.o_release,
                     bus.o_repeat, bus.o_long} !==
                    {m_lvl, m_press, m_rel, m_rpt, m_long}) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b want=%b",
                             cyc,
                             {bus.o_level, bus.o_press, bus.o_release,
                              bus.o_repeat, bus.o_long},
                             {m_lvl, m_press, m_rel, m_rpt, m_long});
                end
            end
            if (bus.o_press === 1'b1) begin
                n_press++; last_press = cyc;
            end
            if (bus.o_release === 1'b1) begin
                n_rel++; last_rel = cyc;
            end
            if (bus.o_repeat === 1'b1) begin
                n_rpt++;
                if (first_rpt < 0) first_rpt = cyc;
            end
            if (bus.o_long === 1'b1) begin
                last_long = cyc;
                if (first_long < 0) first_long = cyc;
            end
        end
    end

    task automatic check(input string name, input int act,
                         input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic clear();
        n_press = 0; n_rel = 0; n_rpt = 0;
        last_press = -1; last_rel = -1; first_rpt = -1;
        first_long = -1; last_long = -1;
    endtask

    task automatic hold(input bit raw, input int n);
        bus.i_btn = raw;
        repeat (n) @(negedge clk);
    endtask

    int k, r, len;
    bit lvl;

    initial begin
        rst_n = 1'b0;
        bus.i_btn = 1'b1;
        clear();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n = 1'b1;

        clear();
        hold(1, 30);
        check("idle_pulses", n_press + n_rel + n_rpt, 0);
        check("idle_level", int'(bus.o_level), 0);

        clear();
        k = cyc + 1;
        hold(0, 8);
        r = cyc + 1;
        hold(1, 12);
        check("short_press_t", last_press, k + 6);
        check("short_rel_t", last_rel, r + 6);
        check("short_rpt_n", n_rpt, 0);
        check("short_press_n", n_press, 1);

        clear();
        hold(0, 3);
        hold(1, 1);
        hold(0, 3);
        hold(1, 15);
        check("bounce_press_n", n_press, 0);
        check("bounce_level", int'(bus.o_level), 0);

        clear();
        k = cyc + 1;
        hold(0, 40);
        r = cyc + 1;
        hold(1, 15);
        check("long_press_t", last_press, k + 6);
        check("long_rpt_first", first_rpt, k + 16);
        check("long_rpt_n", n_rpt, 9);
        check("long_rise_t", first_long, k + 16);
        check("long_rel_t", last_rel, r + 6);
        check("long_fall_t", last_long, r + 5);

        clear();
        k = cyc + 1;
        hold(0, 10);
        hold(1, 2);
        hold(0, 20);
        r = cyc + 1;
        hold(1, 15);
        check("rb_press_n", n_press, 1);
        check("rb_rel_n", n_rel, 1);
        check("rb_rpt_first", first_rpt, k + 24);
        check("rb_rel_t", last_rel, r + 6);

        clear();
        hold(0, 25);
        check("pre_rst_long", int'(bus.o_long), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async",
              int'({bus.o_level, bus.o_press, bus.o_release,
                    bus.o_repeat, bus.o_long}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear();
        k = cyc + 1;
        hold(0, 25);
        check("post_rst_press_t", last_press, k + 6);
        check("post_rst_long_t", first_long, k + 16);
        check("post_rst_rpt_t", first_rpt, k + 16);
        hold(1, 15);

        for (int i = 0; i < 300; i++) begin
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                len = int'($urandom_range(15, 40));
            else
                len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            hold(lvl, len);
        end
        hold(1, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
